// File: rtl/sdram_port_arbiter_pkg.sv
// drfm_sdram_pkg: shared types and constants for the SDRAM master port arbiter
package drfm_sdram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_BURST = 2'd2} arb_state_t;
  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;
  localparam logic [1:0] SDRAM_BE_ALL = 2'b11;
endpackage

// File: rtl/sdram_rd_tracker.sv
// sdram_rd_tracker: counts reads in flight, registers returned data, flags unexpected returns
module sdram_rd_tracker
  import drfm_sdram_pkg::*;
#(
  parameter int DATA_W          = SDRAM_DATA_W,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic              issue,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        outstanding,
  output logic [4:0]        outstanding_next,
  output logic              can_issue,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rsp_err
);
  logic rsp_ok;
  // a return only counts when something is actually in flight
  always_comb begin
    rsp_ok           = rsp_valid && outstanding != '0;
    outstanding_next = outstanding + 5'(issue) - 5'(rsp_ok);
    can_issue        = outstanding < 5'(MAX_OUTSTANDING);
  end
  // in-flight count, one-stage response register and sticky error flag
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      outstanding <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      rd_valid    <= rsp_ok;
      if (rsp_ok) rd_data <= rsp_data;
      if (rsp_valid && outstanding == '0) rsp_err <= 1'b1;
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: burst-based round-robin sharing of one SDRAM Avalon master between capture and playback
module sdram_port_arbiter
  import drfm_sdram_pkg::*;
#(
  parameter int ADDR_W          = SDRAM_ADDR_W,
  parameter int DATA_W          = SDRAM_DATA_W,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [4:0]        outstanding,
  output logic [1:0]        owner,
  output logic              rsp_err
);
  arb_state_t state;
  logic [7:0] burst_cnt;
  logic       last_rd;
  logic       rd_eligible;
  logic       can_issue;
  logic       burst_last;
  logic [4:0] outstanding_next;

  assign owner          = state;
  assign avm_byteenable = SDRAM_BE_ALL;

  // command bus follows the current owner combinationally; a stall blocks the ack
  always_comb begin
    rd_eligible   = rd_req && can_issue;
    avm_write     = state == WR_BURST && wr_req;
    avm_read      = state == RD_BURST && rd_eligible;
    avm_address   = state == WR_BURST ? wr_addr : state == RD_BURST ? rd_addr : '0;
    avm_writedata = state == WR_BURST ? wr_data : '0;
    wr_ack        = avm_write && !avm_waitrequest;
    rd_ack        = avm_read && !avm_waitrequest;
    burst_last    = burst_cnt == 8'(MAX_BURST - 1);
  end

  // ownership FSM: ties go to whoever was not served last, bursts capped by beats and read credit
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_rd   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (wr_req && (!rd_eligible || last_rd)) state <= WR_BURST;
          else if (rd_eligible) state <= RD_BURST;
        end
        WR_BURST: begin
          if (wr_ack) burst_cnt <= burst_cnt + 8'd1;
          if (!wr_req || (wr_ack && burst_last)) begin
            state   <= IDLE;
            last_rd <= 1'b0;
          end
        end
        RD_BURST: begin
          if (rd_ack) burst_cnt <= burst_cnt + 8'd1;
          if (!rd_req || (rd_ack && burst_last) || outstanding_next == 5'(MAX_OUTSTANDING)) begin
            state   <= IDLE;
            last_rd <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sdram_rd_tracker #(
    .DATA_W         (DATA_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_rd_tracker (
    .M100CLK         (M100CLK),
    .reset           (reset),
    .issue           (rd_ack),
    .rsp_valid       (avm_readdatavalid),
    .rsp_data        (avm_readdata),
    .outstanding     (outstanding),
    .outstanding_next(outstanding_next),
    .can_issue       (can_issue),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rsp_err         (rsp_err)
  );
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 16-bit SDRAM Avalon-MM master port between two requesters.
  - Capture writer: ADC samples into SDRAM.
  - Playback reader: delayed read-back feeding the RAM buffer, Arbiter and Scaler chain.
- Replaces the switch-selected static master mux with a burst-based round-robin scheduler.
- Caps outstanding reads so the downstream 2K-word RAM buffer cannot be overrun.
- Sits between the requesters and the SDRAM controller. All Avalon signals on this block are active-high.

Parameters:
- ADDR_W, 25, SDRAM word address width
- DATA_W, 16, data width
- MAX_BURST, 8, maximum beats granted per ownership period (range 1..255)
- MAX_OUTSTANDING, 16, maximum reads issued but not yet returned (range 1..31)

Ports:
- M100CLK  in  1  system clock; the only clock in the block
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  capture requester has a word to write
- wr_addr  in  ADDR_W  capture write address
- wr_data  in  DATA_W  capture write data
- wr_ack  out  1  capture beat accepted this cycle
- rd_req  in  1  playback requester wants a read
- rd_addr  in  ADDR_W  playback read address
- rd_ack  out  1  read command accepted this cycle
- rd_data  out  DATA_W  returned read data
- rd_valid  out  1  rd_data valid
- avm_address  out  ADDR_W  Avalon address
- avm_write  out  1  Avalon write
- avm_read  out  1  Avalon read
- avm_writedata  out  DATA_W  Avalon write data
- avm_byteenable  out  2  Avalon byte enables; constant 2'b11
- avm_waitrequest  in  1  Avalon stall
- avm_readdata  in  DATA_W  Avalon read data
- avm_readdatavalid  in  1  Avalon read data valid
- outstanding  out  5  reads in flight (status)
- owner  out  2  current state encoding (status)
- rsp_err  out  1  sticky flag: read data returned with nothing outstanding

Behaviour:

Reset
- Clock and reset: one clock, M100CLK. reset is synchronous and active-high.
- Reset values:
  - state = IDLE, outstanding = 0, burst count = 0, rsp_err = 0.
  - last_served = READ, so the writer wins the first tie.
  - rd_valid = 0, rd_data = 0.
- Reset mid-operation: returns to IDLE the next cycle and drops all tracking.
- Read data returning after reset is treated as unexpected (see Read-response tracking).

State machine: IDLE, WR_BURST, RD_BURST
- IDLE
  - Drives avm_read = avm_write = 0, wr_ack = rd_ack = 0.
  - rd_eligible = rd_req && outstanding < MAX_OUTSTANDING.
  - If only wr_req: go to WR_BURST.
  - If only rd_eligible: go to RD_BURST.
  - If both: go to the requester opposite last_served.
  - Otherwise stay in IDLE.
  - Burst count is cleared on every transition out of IDLE.
- WR_BURST
  - Outputs are combinational from the inputs: avm_write = wr_req, avm_address = wr_addr, avm_writedata = wr_data.
  - wr_ack = wr_req && !avm_waitrequest; each ack increments burst count.
  - Return to IDLE and set last_served = WRITE when either:
    - wr_req == 0, or
    - an accepted beat brings the count to MAX_BURST.
- RD_BURST
  - avm_read = rd_req && outstanding < MAX_OUTSTANDING; avm_address = rd_addr.
  - rd_ack = avm_read && !avm_waitrequest; each ack increments burst count.
  - Exit to IDLE and set last_served = READ when any of these holds:
    - rd_req == 0;
    - an ack brings the count to MAX_BURST;
    - outstanding (after update) reaches MAX_OUTSTANDING.

Command-path rules
- Latency: a request seen in IDLE at cycle N gets its first command on the bus at cycle N+1.
- Requesters hold address and data stable until ack.
- avm_waitrequest high holds the command unchanged and blocks ack. The burst does not end while a beat is stalled.

Read-response tracking
- outstanding increments on rd_ack and decrements on avm_readdatavalid.
- Both in the same cycle leaves it unchanged.
- It never wraps.
- Data path: rd_data/rd_valid are avm_readdata/avm_readdatavalid registered once, so data is valid one cycle after avm_readdatavalid.
- avm_readdatavalid with outstanding == 0:
  - data is discarded and rd_valid stays 0;
  - rsp_err is set;
  - outstanding stays 0.
- rsp_err clears only on reset.
- Read returns are accepted in every state, including during WR_BURST.

Decomposition:
- Package drfm_sdram_pkg holds:
  - the arb_state_t enum: IDLE = 0, WR_BURST = 1, RD_BURST = 2;
  - constants SDRAM_ADDR_W = 25, SDRAM_DATA_W = 16, SDRAM_BE_ALL = 2'b11.
- One sub-module, sdram_rd_tracker, holds:
  - the outstanding counter, its saturation compare and the registered response stage;
  - the rsp_err flag.

Test Plan:
- Write only: reset, hold wr_req for 20 words at addresses 0..19 with waitrequest = 0.
  - Response: bursts of exactly 8, 8, 4 acks.
  - One IDLE cycle between bursts.
  - avm_address follows 0..19.
- Contention: wr_req and rd_req both constantly high.
  - Response: the first grant goes to WR_BURST.
  - Grants then alternate WR, RD, WR, RD, each burst 8 beats.
- Outstanding cap: rd_req high, avm_readdatavalid held low.
  - Response: exactly 16 rd_acks, then avm_read = 0 and outstanding = 16.
  - After one avm_readdatavalid pulse, one more read is issued.
- Waitrequest stall: assert avm_waitrequest for 5 cycles mid-write.
  - Response: avm_write, address and data are held; no wr_ack during the stall.
  - Burst count is unchanged by the stall.
- Simultaneous ack and return: rd_ack and avm_readdatavalid in the same cycle at outstanding = 3.
  - Response: outstanding stays 3.
  - rd_valid pulses the next cycle with data 16'hA5A5.
- Reset and unexpected data: assert reset in RD_BURST with 4 reads outstanding, then return 1 word.
  - Response: state = IDLE and outstanding = 0.
  - rsp_err = 1 and rd_valid stays 0.
